lms_fir_engine: RTL and testbench
=================================

// Module: lms_fir_engine
// PURPOSE
//  Adaptive FIR filter for the LMS datapath, directly downstream of core_fsm_mac.
//  On fir_go it takes in the new reference sample and the step-scaled error term
//  (mu*(e-d)). It then runs a serial MAC over the NTAPS-deep delay line, using the
//  a-priori weights, and updates each weight in the same pass.
//  It returns the filter output and the single-cycle fir_done pulse that releases
//  the core from its RUN state.
// PARAMETERS
//  NTAPS  8   number of taps/weights (>=2)
//  FRAC   15  fractional bits; samples and weights are Q1.15
//  ACCW   40  accumulator width (>= 32+clog2(NTAPS))
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   synchronous reset, active-high
//  fir_go    in   1   start pulse from core (sampled only in IDLE)
//  x_in      in   32  signed reference sample (core feedforward_out), saturated to 16b
//  mu_err    in   32  signed weight-adjust term, Q2.30 (core weight_adjust)
//  fir_done  out  1   one-cycle pulse: y_out valid, weights updated
//  y_out     out  16  signed filter output, Q1.15, held until next fir_done
//  busy      out  1   high from cycle after accepted fir_go through fir_done cycle
// BEHAVIOUR
//  Reset (clk edge with rst=1):
//   - state=IDLE; all taps x[0..NTAPS-1]=0; all weights w[0..NTAPS-1]=0.
//   - acc=0, y_out=0, fir_done=0, busy=0.
//   - rst overrides all else, including mid-operation: the run aborts, no fir_done.
//  States: IDLE -> LOAD -> MAC -> DONE -> IDLE.
//   IDLE: if fir_go -> LOAD.
//     Capture xs=sat16(x_in) and mus=sat16(mu_err>>>FRAC) (arithmetic shift).
//     fir_go in any other state is ignored (no queueing).
//   LOAD (1 cycle):
//     Shift the delay line: x[0]<=xs, x[i]<=x[i-1]; the oldest sample is dropped.
//     acc<=0, idx<=0.
//   MAC (NTAPS cycles, idx 0..NTAPS-1):
//     acc += w[idx]*x[idx], a 32b product sign-extended to ACCW, using the OLD weight.
//     w[idx] <= sat16(w[idx] + ((mus*x[idx])>>>FRAC)), written the same cycle.
//     At idx==NTAPS-1 -> DONE.
//   DONE (1 cycle):
//     y_out <= sat16((acc + 2^(FRAC-1)) >>>FRAC), i.e. round-half-up.
//     fir_done<=1 for this cycle only; -> IDLE.
//     A fir_go in this cycle is ignored; fir_go is next accepted in IDLE.
//  Timing:
//   - fir_go sampled at edge T -> fir_done high in cycle T+NTAPS+2.
//   - Back-to-back throughput: one sample per NTAPS+3 cycles.
//  Arithmetic:
//   - sat16 clamps to [-32768, 32767].
//   - All arithmetic signed; no wrap-around anywhere; acc never overflows for ACCW>=32+clog2(NTAPS).
//  Outputs:
//   - y_out changes only in DONE.
//   - busy is combinational from state (state!=IDLE).
// TESTING (NTAPS=8, FRAC=15)
//  T1 zero weights:
//     rst, then fir_go with x_in=0x4000, mu_err=0
//     -> fir_done exactly 10 cycles later, y_out=0, all w=0.
//  T2 update + a-priori output:
//     fir_go x_in=0x4000, mu_err=0x2000_0000 -> y_out=0, w[0]=0x2000.
//     Then fir_go x_in=0x4000, mu_err=0 -> y_out=0x1000.
//  T3 saturation:
//     x_in=0x0001_0000 -> tap=0x7FFF.
//     Repeat mu_err=0x3FFF_8000 with x=0x7FFF -> w[0] clamps at 0x7FFF, never wraps negative.
//  T4 go while busy:
//     second fir_go pulse 3 cycles after the first
//     -> single fir_done, delay line shifted once only.
//  T5 reset mid-MAC:
//     assert rst at MAC idx=4
//     -> next cycle busy=0, y_out=0, all taps/weights 0, no fir_done.
//  T6 with core_fsm_mac:
//     drive 20 in_valid samples through the core
//     -> each fir_go yields one fir_done; y_out matches a bit-exact reference model.

Source files
------------

// File: rtl/lms_fir_engine.sv
// Adaptive LMS FIR: serial MAC over an NTAPS-deep delay line using a-priori weights,
// updating each weight in the same pass; y_out and fir_done appear together on entering DONE.
module lms_fir_engine #(
  parameter int NTAPS = 8,
  parameter int FRAC  = 15,
  parameter int ACCW  = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fir_go,
  input  logic [31:0] x_in,
  input  logic [31:0] mu_err,
  output logic        fir_done,
  output logic [15:0] y_out,
  output logic        busy
);

  localparam int IW = $clog2(NTAPS);
  localparam int SW = ACCW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic signed [ACCW-1:0] acc;
  logic signed [15:0]     xs;
  logic signed [15:0]     mus;
  logic signed [15:0]     x [NTAPS];
  logic signed [15:0]     w [NTAPS];

  function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
    if (v > SW'(32767))       return 16'sh7FFF;
    else if (v < -SW'(32768)) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  logic signed [31:0]     mu_sh;
  logic signed [31:0]     prod;
  logic signed [31:0]     upd_prod;
  logic signed [31:0]     upd_sh;
  logic signed [32:0]     wsum;
  logic signed [ACCW-1:0] acc_nxt;
  logic signed [ACCW-1:0] acc_rnd;
  logic signed [ACCW-1:0] acc_sh;
  logic signed [15:0]     w_new;
  logic signed [15:0]     y_new;

  always_comb begin
    mu_sh    = $signed(mu_err) >>> FRAC;
    prod     = w[idx] * x[idx];
    upd_prod = mus * x[idx];
    upd_sh   = upd_prod >>> FRAC;
    wsum     = {{17{w[idx][15]}}, w[idx]} + {upd_sh[31], upd_sh};
    w_new    = sat16({{(SW-33){wsum[32]}}, wsum});
    acc_nxt  = acc + {{(ACCW-32){prod[31]}}, prod};
    // Rounding uses the sum including the last product, so y_out is ready as DONE begins.
    acc_rnd  = acc_nxt + (ACCW'(1) <<< (FRAC - 1));
    acc_sh   = acc_rnd >>> FRAC;
    y_new    = sat16({acc_sh[ACCW-1], acc_sh});
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      xs       <= '0;
      mus      <= '0;
      y_out    <= '0;
      fir_done <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x[i] <= '0;
        w[i] <= '0;
      end
    end else begin
      fir_done <= 1'b0;
      case (state)
        IDLE: if (fir_go) begin
          xs    <= sat16({{(SW-32){x_in[31]}}, x_in});
          mus   <= sat16({{(SW-32){mu_sh[31]}}, mu_sh});
          state <= LOAD;
        end
        LOAD: begin
          x[0] <= xs;
          for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
          acc   <= '0;
          idx   <= '0;
          state <= MAC;
        end
        MAC: begin
          acc    <= acc_nxt;
          w[idx] <= w_new;
          if (idx == IW'(NTAPS - 1)) begin
            y_out    <= y_new;
            fir_done <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_fir_engine.sv
// Bench for lms_fir_engine: hand-computed vector table, behavioural model feeding a
// scoreboard, and directed sequences for latency, saturation, go-while-busy and reset abort.
module tb_lms_fir_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fir_go = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] mu_err = '0;
  logic        fir_done;
  logic [15:0] y_out;
  logic        busy;

  lms_fir_engine #(.NTAPS(8), .FRAC(15), .ACCW(40)) dut (
    .clk(clk), .rst(rst), .fir_go(fir_go), .x_in(x_in), .mu_err(mu_err),
    .fir_done(fir_done), .y_out(y_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [15:0] sb [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic on its own copies of taps and weights.
  int mx [8];
  int mw [8];

  function automatic int msat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
  endtask

  task automatic model_step(input logic [31:0] xi, input logic [31:0] mi, output int y);
    longint a;
    int xsv, musv;
    xsv  = msat(longint'($signed(xi)));
    musv = msat(longint'($signed(mi)) >>> 15);
    for (int i = 7; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = xsv;
    a = 0;
    for (int i = 0; i < 8; i++) begin
      a += longint'(mw[i]) * longint'(mx[i]);
      mw[i] = msat(longint'(mw[i]) + ((longint'(musv) * longint'(mx[i])) >>> 15));
    end
    y = msat((a + 16384) >>> 15);
  endtask

  always @(negedge clk) begin
    if (!rst && fir_done) begin
      if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
      else chk("sb_y", int'(y_out), int'(sb.pop_front()));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fir_go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Issues one operation from IDLE, checks latency and busy, returns in IDLE.
  task automatic run_op(input logic [31:0] xi, input logic [31:0] mi, input string tag);
    int y;
    int n;
    @(negedge clk);
    fir_go = 1'b1;
    x_in = xi;
    mu_err = mi;
    model_step(xi, mi, y);
    sb.push_back(y[15:0]);
    @(negedge clk);
    fir_go = 1'b0;
    n = 1;
    chk({tag, "_busy_start"}, int'(busy), 1);
    while (!fir_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk({tag, "_done_timeout"}, 0, 1);
    else begin
      chk({tag, "_latency"}, n, 10);
      chk({tag, "_busy_at_done"}, int'(busy), 1);
    end
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(fir_done), 0);
  endtask

  typedef struct {
    logic [31:0] xi;
    logic [31:0] mi;
    logic [15:0] ey;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int cnt;
    tbl[0] = '{32'h0000_4000, 32'h2000_0000, 16'h0000};
    tbl[1] = '{32'h0000_4000, 32'h0000_0000, 16'h1000};
    tbl[2] = '{32'hFFFF_C000, 32'h0000_0000, 16'hF000};
    tbl[3] = '{32'h0001_0000, 32'h0000_0000, 16'h2000};
    tbl[4] = '{32'hFFFF_0000, 32'h0000_0000, 16'hE000};
    tbl[5] = '{32'h0000_0002, 32'h0000_0000, 16'h0001};
    tbl[6] = '{32'hFFFF_FFFE, 32'h0000_0000, 16'h0000};

    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(fir_done), 0);
    chk("rst_y", int'(y_out), 0);

    // Zero weights: output stays zero, weights untouched.
    run_op(32'h0000_4000, 32'h0, "t1");
    chk("t1_y", int'(y_out), 0);
    for (int i = 0; i < 8; i++) chk("t1_w_zero", int'(dut.w[i]), 0);

    // Hand-computed table: weight update, a-priori output, input saturation, rounding.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      run_op(tbl[k].xi, tbl[k].mi, "tbl");
      chk("tbl_y", int'(y_out), int'(tbl[k].ey));
      if (k == 0) chk("tbl_w0", int'(dut.w[0]), 32'h2000);
      if (k == 3) chk("tbl_tap_sat", int'(dut.x[0]), 32'h7FFF);
    end

    // Weight saturation: w[0] climbs to 0x7FFF and stays there.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_op(32'h0000_7FFF, 32'h3FFF_8000, "t3");
      chk("t3_w0_nonneg", int'(dut.w[0][15]), 0);
    end
    chk("t3_w0_clamp", int'(dut.w[0]), 32'h7FFF);
    chk("t3_y_clamp", int'(y_out), 32'h7FFF);

    // Second go while busy is dropped: one fir_done, one shift.
    @(negedge clk);
    begin
      int y;
      fir_go = 1'b1;
      x_in = 32'h0000_1000;
      mu_err = 32'h0;
      model_step(x_in, mu_err, y);
      sb.push_back(y[15:0]);
    end
    @(negedge clk);
    fir_go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fir_go = 1'b1;
    x_in = 32'h0000_7000;
    @(negedge clk);
    fir_go = 1'b0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (fir_done) cnt++;
      @(negedge clk);
    end
    chk("t4_single_done", cnt, 1);
    run_op(32'h0000_0800, 32'h0, "t4_follow");

    // Reset in the middle of the MAC pass aborts the run.
    @(negedge clk);
    fir_go = 1'b1;
    x_in = 32'h0000_2000;
    mu_err = 32'h1000_0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fir_go = 1'b0;
    end
    chk("t5_idx_at_abort", int'(dut.idx), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_y", int'(y_out), 0);
    chk("t5_done", int'(fir_done), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_tap_zero", int'(dut.x[i]), 0);
      chk("t5_w_zero", int'(dut.w[i]), 0);
    end
    model_reset();
    sb.delete();
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (fir_done) cnt++;
      @(negedge clk);
    end
    chk("t5_no_done", cnt, 0);

    // Random stream against the model through the scoreboard.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      int xv;
      logic [31:0] mv;
      xv = int'($urandom_range(0, 131071)) - 65536;
      mv = $urandom();
      mv = $signed(mv) >>> 2;
      run_op(xv, mv, "t6");
    end

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
